pcie_us_msi_sched: RTL
======================

// Module: pcie_us_msi_sched
// PURPOSE
//  Schedules MSI interrupts from IRQ_COUNT internal requesters onto the single UltraScale+ PCIe hard-IP MSI port (function 0).
//  Latches request pulses as pending bits, grants them round-robin, pulses one cfg_interrupt_msi_int bit and waits for sent/fail.
//  Retries after a backoff on fail or timeout. Sits between fpga_core logic and the PCIe IP cfg_interrupt_msi_* pins.
// PARAMETERS
//  IRQ_COUNT     32    number of requesters, 1..32
//  RETRY_DELAY   16    idle cycles after fail/timeout before the next issue, >=1
//  WAIT_TIMEOUT  1024  cycles in WAIT with no sent/fail before the attempt is treated as a fail
// PORTS
//  clk                               in   1          clock, 250 MHz
//  rst                               in   1          reset, asynchronous, active-high
//  irq_req                           in   IRQ_COUNT  per-requester request pulses, 1 cycle each
//  irq_pending                       out  IRQ_COUNT  current pending register
//  cfg_interrupt_msi_enable          in   4          bit0 = MSI enabled for function 0
//  cfg_interrupt_msi_mmenable        in   12         bits[2:0] = log2 of allocated vectors for function 0
//  cfg_interrupt_msi_int             out  32         one-hot MSI vector pulse
//  cfg_interrupt_msi_sent            in   1          IP reports the MSI was sent
//  cfg_interrupt_msi_fail            in   1          IP reports the MSI failed
//  cfg_interrupt_msi_select          out  4          constant 0
//  cfg_interrupt_msi_function_number out  4          constant 0
//  cfg_interrupt_msi_attr            out  3          constant 0
//  stat_msi_sent                     out  1          1-cycle pulse per successful MSI
//  stat_msi_fail                     out  1          1-cycle pulse per fail or timeout
// BEHAVIOUR
//  Reset: pending=0, msi_int=0, stat_*=0, state=IDLE, rr_ptr=0, counters=0.
//  Pending update each cycle: pending <= (pending & ~clr) | irq_req.
//   - clr is set only for the granted bit, on sent.
//   - Set wins over clear for the same bit.
//  Vector mapping:
//   - nvec = 2**min(mmenable[2:0],5).
//   - irq i maps to vector (i mod nvec), i.e. i & (nvec-1).
//  FSM:
//   - IDLE: if msi_enable[0] and pending!=0, grant the first pending bit at or after rr_ptr (cyclic), latch gnt_idx -> ISSUE.
//     If disabled, requests remain pending; nothing is dropped.
//   - ISSUE: msi_int registered one-hot at the mapped vector for exactly 1 cycle; clear timeout counter -> WAIT.
//   - WAIT:
//     - on sent: clear pending[gnt_idx], pulse stat_msi_sent, rr_ptr <= gnt_idx+1 (wraps to 0 past IRQ_COUNT-1) -> IDLE.
//     - on fail or timeout==WAIT_TIMEOUT-1: bit stays pending, pulse stat_msi_fail, rr_ptr <= gnt_idx+1 -> BACKOFF.
//     - sent and fail in the same cycle: treated as sent.
//     - sent/fail arriving outside WAIT is ignored.
//   - BACKOFF: count RETRY_DELAY cycles -> IDLE.
//  Latency: irq_req high in cycle N -> pending visible in N+1 -> grant in N+1 -> msi_int high in cycle N+2.
//   Minimum spacing between msi_int pulses is 3 cycles (ISSUE, WAIT with same-cycle sent, IDLE).
//  Exactly one msi_int outstanding at any time.
//  Enable dropping in WAIT or BACKOFF: the FSM completes normally, then holds in IDLE.
//  mmenable changing mid-attempt: the vector latched in ISSUE is used.
//  Asynchronous reset mid-operation: everything returns to reset values; the in-flight MSI is forgotten and a late sent is ignored.
//  Counter widths: $clog2(WAIT_TIMEOUT) and $clog2(RETRY_DELAY+1); rr_ptr $clog2(IRQ_COUNT) (min 1).
// STRUCTURE
//  No shared package needed; FSM state encodings and mapping logic stay as local parameters.
//  One natural sub-module: msi_rr_arbiter (IRQ_COUNT request vector + rr_ptr -> gnt_valid, gnt_idx, combinational).
//  Everything else (FSM, counters, pending register) is in the top level.
// TESTING
//  1. enable=1, mmenable=5, pulse irq_req[3] -> msi_int=0x8 two cycles later for 1 cycle; sent -> pending[3]=0, stat_msi_sent=1.
//  2. irq_req=0x0000_0011 simultaneously, sent returned immediately -> msi_int 0x1 then 0x10; rr_ptr ends at 5; pending=0.
//  3. mmenable=2 (4 vectors), irq_req[6] -> msi_int=0x4 (6 mod 4 = 2).
//  4. fail on first attempt for irq 0 -> stat_msi_fail, 16 idle cycles, reissue 0x1; with irq 1 also pending, irq 1 is issued before the retry of irq 0.
//  5. no sent/fail -> stat_msi_fail at WAIT cycle 1024; enable=0 -> pending held, no msi_int; re-enable -> issue.
//  6. irq_req[2] in the same cycle as sent for irq 2 -> pending[2] stays 1 and is reissued; rst in WAIT -> all outputs 0 next cycle, a late sent does not pulse stat_msi_sent.

Source files
------------

// File: rtl/pcie_us_msi_sched_pkg.sv
// Shared types and the requester-to-MSI-vector mapping for the MSI scheduler.
package pcie_us_msi_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StBackoff
  } state_e;

  // One-hot vector for a requester index, folded onto the allocated vector count.
  function automatic logic [31:0] msi_vector(input logic [4:0] idx, input logic [2:0] mm);
    logic [2:0] m;
    logic [4:0] mask;
    m    = (mm > 3'd5) ? 3'd5 : mm;
    mask = 5'((6'd1 << m) - 6'd1);
    return 32'd1 << (idx & mask);
  endfunction

endpackage

// File: rtl/pcie_us_msi_sched_if.sv
// UltraScale+ PCIe hard-IP cfg_interrupt_msi_* pin group for function 0.
interface pcie_us_msi_sched_if;
  logic [3:0]  cfg_interrupt_msi_enable;
  logic [11:0] cfg_interrupt_msi_mmenable;
  logic [31:0] cfg_interrupt_msi_int;
  logic        cfg_interrupt_msi_sent;
  logic        cfg_interrupt_msi_fail;
  logic [3:0]  cfg_interrupt_msi_select;
  logic [3:0]  cfg_interrupt_msi_function_number;
  logic [2:0]  cfg_interrupt_msi_attr;

  modport master (
    input  cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
    input  cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
    output cfg_interrupt_msi_int, cfg_interrupt_msi_select,
    output cfg_interrupt_msi_function_number, cfg_interrupt_msi_attr
  );

  modport slave (
    output cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
    output cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
    input  cfg_interrupt_msi_int, cfg_interrupt_msi_select,
    input  cfg_interrupt_msi_function_number, cfg_interrupt_msi_attr
  );
endinterface

// File: rtl/pcie_us_msi_sched_msi_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, cyclically.
module pcie_us_msi_sched_msi_rr_arbiter #(
  parameter int unsigned IRQ_COUNT = 32,
  parameter int unsigned PTR_W     = 5
) (
  input  logic [IRQ_COUNT-1:0] req,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic                 gnt_valid,
  output logic [PTR_W-1:0]     gnt_idx
);

  int               jj;
  logic [PTR_W-1:0] j;

  // Scan from farthest to nearest so the nearest hit is the last assignment.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    jj        = 0;
    j         = '0;
    for (int k = int'(IRQ_COUNT) - 1; k >= 0; k--) begin
      jj = int'(rr_ptr) + k;
      if (jj >= int'(IRQ_COUNT)) jj = jj - int'(IRQ_COUNT);
      j = PTR_W'(jj);
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = j;
      end
    end
  end

endmodule

// File: rtl/pcie_us_msi_sched.sv
// MSI scheduler: latches request pulses, grants round-robin, issues one MSI at a time
// and retries after a backoff on fail or timeout.
module pcie_us_msi_sched
  import pcie_us_msi_sched_pkg::*;
#(
  parameter int unsigned IRQ_COUNT    = 32,
  parameter int unsigned RETRY_DELAY  = 16,
  parameter int unsigned WAIT_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IRQ_COUNT-1:0] irq_req,
  output logic [IRQ_COUNT-1:0] irq_pending,
  pcie_us_msi_sched_if.master  msi,
  output logic                 stat_msi_sent,
  output logic                 stat_msi_fail
);

  localparam int unsigned PtrW = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;
  localparam int unsigned TmoW = $clog2(WAIT_TIMEOUT);
  localparam int unsigned BoW  = $clog2(RETRY_DELAY + 1);

  state_e                 state_q;
  logic [IRQ_COUNT-1:0]   pending_q;
  logic [IRQ_COUNT-1:0]   clr;
  logic [PtrW-1:0]        rr_ptr_q;
  logic [PtrW-1:0]        rr_next;
  logic [PtrW-1:0]        gnt_q;
  logic [PtrW-1:0]        gnt_idx;
  logic                   gnt_valid;
  logic [TmoW-1:0]        tmo_q;
  logic [BoW-1:0]         bo_q;
  logic [31:0]            msi_int_q;
  logic                   stat_sent_q;
  logic                   stat_fail_q;
  logic                   sent;
  logic                   fail;
  logic                   unused_cfg;

  assign sent       = msi.cfg_interrupt_msi_sent;
  assign fail       = msi.cfg_interrupt_msi_fail;
  assign unused_cfg = ^{msi.cfg_interrupt_msi_enable[3:1], msi.cfg_interrupt_msi_mmenable[11:3]};

  pcie_us_msi_sched_msi_rr_arbiter #(
    .IRQ_COUNT (IRQ_COUNT),
    .PTR_W     (PtrW)
  ) u_msi_rr_arbiter (
    .req       (pending_q),
    .rr_ptr    (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    clr = '0;
    if (state_q == StWait && sent) clr[gnt_q] = 1'b1;
    rr_next = (gnt_q == PtrW'(IRQ_COUNT - 1)) ? '0 : gnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      tmo_q       <= '0;
      bo_q        <= '0;
      msi_int_q   <= '0;
      stat_sent_q <= 1'b0;
      stat_fail_q <= 1'b0;
    end else begin
      // A new request for the granted bit survives its own clear.
      pending_q   <= (pending_q & ~clr) | irq_req;
      msi_int_q   <= '0;
      stat_sent_q <= 1'b0;
      stat_fail_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (msi.cfg_interrupt_msi_enable[0] && gnt_valid) begin
            gnt_q     <= gnt_idx;
            msi_int_q <= msi_vector(5'(gnt_idx), msi.cfg_interrupt_msi_mmenable[2:0]);
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          tmo_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (sent) begin
            stat_sent_q <= 1'b1;
            rr_ptr_q    <= rr_next;
            state_q     <= StIdle;
          end else if (fail || tmo_q == TmoW'(WAIT_TIMEOUT - 1)) begin
            stat_fail_q <= 1'b1;
            rr_ptr_q    <= rr_next;
            bo_q        <= '0;
            state_q     <= StBackoff;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StBackoff: begin
          if (bo_q == BoW'(RETRY_DELAY - 1)) state_q <= StIdle;
          else bo_q <= bo_q + 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign irq_pending                           = pending_q;
  assign stat_msi_sent                         = stat_sent_q;
  assign stat_msi_fail                         = stat_fail_q;
  assign msi.cfg_interrupt_msi_int             = msi_int_q;
  assign msi.cfg_interrupt_msi_select          = 4'd0;
  assign msi.cfg_interrupt_msi_function_number = 4'd0;
  assign msi.cfg_interrupt_msi_attr            = 3'd0;

endmodule
